// File: rtl/narrow_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | narrow_pkg : shared widths, saturation values, FIFO occupancy enum   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package narrow_pkg;

  localparam int IN_W  = 20;
  localparam int OUT_W = 8;

  localparam logic [7:0] SAT_POS = 8'h7F;
  localparam logic [7:0] SAT_NEG = 8'h80;
  localparam logic [7:0] SAT_U   = 8'hFF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage
`default_nettype wire

// File: rtl/narrow_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | narrow_fifo : two-entry ordered buffer of {ovf, data} words          |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module narrow_fifo
  import narrow_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  occ_e             state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // The caller gates push with !full and pop with !empty.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    unique case (state_q)
      EMPTY: if (push_i) state_d = ONE;
      ONE: begin
        if (push_i && !pop_i)      state_d = FULL;
        else if (pop_i && !push_i) state_d = EMPTY;
      end
      FULL:    if (pop_i) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (state_q == FULL);
  assign empty_o = (state_q == EMPTY);

endmodule
`default_nettype wire

// File: rtl/narrow_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | narrow_sat : 20->8 bit narrowing with saturate/truncate + ovf stats  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module narrow_sat
  import narrow_pkg::*;
#(
  parameter int IN_W  = narrow_pkg::IN_W,
  parameter int OUT_W = narrow_pkg::OUT_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_signed,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr
);

  logic             accept, pop, fifo_full, fifo_empty;
  logic             fit_s, fit_u, fit, ovf;
  logic [OUT_W-1:0] res_data;
  logic [OUT_W:0]   fifo_rdata;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Signed fit: every bit from the output sign position upward is a copy of it.
  assign fit_s = (&in_data[IN_W-1:OUT_W-1]) || !(|in_data[IN_W-1:OUT_W-1]);
  assign fit_u = !(|in_data[IN_W-1:OUT_W]);
  assign fit   = in_signed ? fit_s : fit_u;
  assign ovf   = !fit;

  always_comb begin
    res_data = in_data[OUT_W-1:0];
    if (sat_en && ovf) begin
      if (!in_signed)          res_data = OUT_W'(SAT_U);
      else if (in_data[IN_W-1]) res_data = OUT_W'(SAT_NEG);
      else                     res_data = OUT_W'(SAT_POS);
    end
  end

  narrow_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i ({ovf, res_data}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign out_ovf   = fifo_rdata[OUT_W];
  assign out_data  = fifo_rdata[OUT_W-1:0];

  // Clear takes effect first so a same-cycle overflow still registers.
  always_comb begin
    cnt_d    = clr ? '0 : cnt_q;
    sticky_d = clr ? 1'b0 : sticky_q;
    if (accept && ovf) begin
      sticky_d = 1'b1;
      if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign ovf_count  = cnt_q;
  assign ovf_sticky = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_narrow_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_narrow_sat : directed vectors for narrow_sat                      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_narrow_sat;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed, sat_en;
  logic [19:0] in_data;
  logic        out_valid, out_ready, out_ovf, ovf_sticky, clr;
  logic [7:0]  out_data, ovf_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int exp_sticky = 0;

  always #5 clk = ~clk;

  narrow_sat #(.IN_W(20), .OUT_W(8), .DEPTH(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_signed  (in_signed),
    .sat_en     (sat_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count),
    .clr        (clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One isolated item through an empty FIFO with the consumer ready.
  task automatic send(input logic [19:0] d, input logic sgn, input logic sat,
                      input logic [7:0] ed, input logic eo);
    @(negedge clk);
    check("idle_before_accept", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_data = d; in_signed = sgn; sat_en = sat; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (eo) begin
      exp_sticky = 1;
      if (exp_cnt != 255) exp_cnt++;
    end
    @(negedge clk);
    check($sformatf("valid_%05h", d), {31'd0, out_valid}, 32'd1);
    check($sformatf("data_%05h_s%0d_t%0d", d, sgn, sat), {24'd0, out_data}, {24'd0, ed});
    check($sformatf("ovf_%05h_s%0d_t%0d", d, sgn, sat), {31'd0, out_ovf}, {31'd0, eo});
    check("ovf_count", {24'd0, ovf_count}, exp_cnt);
    check("ovf_sticky", {31'd0, ovf_sticky}, exp_sticky);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0;
    sat_en = 1'b0; out_ready = 1'b0; clr = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    check("rst_count", {24'd0, ovf_count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // signed, saturating
    send(20'h0000C, 1'b1, 1'b1, 8'h0C, 1'b0);
    send(20'hFFFEC, 1'b1, 1'b1, 8'hEC, 1'b0);
    send(20'h0007F, 1'b1, 1'b1, 8'h7F, 1'b0);
    send(20'hFFF80, 1'b1, 1'b1, 8'h80, 1'b0);
    send(20'h00080, 1'b1, 1'b1, 8'h7F, 1'b1);
    send(20'h00100, 1'b1, 1'b1, 8'h7F, 1'b1);
    send(20'hFFE00, 1'b1, 1'b1, 8'h80, 1'b1);
    send(20'hFFF7F, 1'b1, 1'b1, 8'h80, 1'b1);
    // truncating
    send(20'h00100, 1'b1, 1'b0, 8'h00, 1'b1);
    send(20'hFFE35, 1'b1, 1'b0, 8'h35, 1'b1);
    send(20'hFFFFF, 1'b0, 1'b0, 8'hFF, 1'b1);
    // unsigned, saturating
    send(20'h000FF, 1'b0, 1'b1, 8'hFF, 1'b0);
    send(20'h00100, 1'b0, 1'b1, 8'hFF, 1'b1);
    send(20'hFFFFF, 1'b0, 1'b1, 8'hFF, 1'b1);
    send(20'h00080, 1'b0, 1'b1, 8'h80, 1'b0);

    // Backpressure: fill the FIFO, then drain in order.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 20'h00001; in_signed = 1'b0; sat_en = 1'b1;
    @(negedge clk);
    check("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
    in_data = 20'h00002;
    @(negedge clk);
    check("bp_ready_full", {31'd0, in_ready}, 32'd0);
    check("bp_head_0", {24'd0, out_data}, 32'h01);
    in_data = 20'h00003;
    @(negedge clk);
    check("bp_ready_still_full", {31'd0, in_ready}, 32'd0);
    check("bp_head_held", {24'd0, out_data}, 32'h01);
    check("bp_valid_held", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
    check("bp_head_1", {24'd0, out_data}, 32'h02);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_head_2", {24'd0, out_data}, 32'h03);
    check("bp_valid_2", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    check("bp_count", {24'd0, ovf_count}, exp_cnt);

    // Saturating counter: start from a cleared state.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; exp_cnt = 0; exp_sticky = 0;
    check("clr_count", {24'd0, ovf_count}, 32'd0);
    in_valid = 1'b1; in_data = 20'h00100; in_signed = 1'b0; sat_en = 1'b1; out_ready = 1'b1;
    n_acc = 0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      if (in_ready) n_acc++;
      if (n_acc >= 300) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("cnt_accepts", n_acc, 32'd300);
    repeat (3) @(negedge clk);
    check("cnt_saturated", {24'd0, ovf_count}, 32'd255);
    check("cnt_sticky", {31'd0, ovf_sticky}, 32'd1);
    clr = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clr_ovf_count", {24'd0, ovf_count}, 32'd1);
    check("clr_ovf_sticky", {31'd0, ovf_sticky}, 32'd1);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_only_count", {24'd0, ovf_count}, 32'd0);
    check("clr_only_sticky", {31'd0, ovf_sticky}, 32'd0);

    // Asynchronous reset with the FIFO full.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 20'h00100;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    check("pre_rst_count", {24'd0, ovf_count}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_count", {24'd0, ovf_count}, 32'd0);
    check("async_rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    check("async_rst_data", {24'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0; exp_sticky = 0;
    send(20'hFFFEC, 1'b1, 1'b1, 8'hEC, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
